// File: rtl/vectors_pkg.sv
// Shared types for the packed-vector receive path: FSM states, beat indices
// and the half-vector beat width.
package vectors_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        A_LO = 2'd0,
        A_HI = 2'd1,
        B_LO = 2'd2,
        B_HI = 2'd3
    } beat_t;

    function automatic int half_w(input int nbits, input int br_size);
        return nbits * br_size / 2;
    endfunction

endpackage

// File: rtl/half_unpacker.sv
// One register bank holding half of a vector, loaded from a packed beat
// with element i taken from bits [(i+1)*NBITS-1 : i*NBITS].
module half_unpacker #(
    parameter int NBITS = 8,
    parameter int HALF  = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_we,
    input  logic [NBITS*HALF-1:0]   i_word,
    output logic [NBITS-1:0]        o_elem [HALF-1:0]
);

    logic [NBITS-1:0] r_mem [HALF-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HALF; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < HALF; i++) begin
                r_mem[i] <= i_word[i*NBITS +: NBITS];
            end
        end
    end

    assign o_elem = r_mem;

endmodule

// File: rtl/vectors_unpacker.sv
// Reassembles four half-vector beats into arrays A and B and holds the pair
// under a valid/ready handshake; flags misplaced in_last as a framing error.
module vectors_unpacker
    import vectors_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int BR_SIZE = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [half_w(NBITS, BR_SIZE)-1:0]      in_data,
    input  logic                                   in_valid,
    input  logic                                   in_last,
    output logic                                   in_ready,
    output logic [NBITS-1:0]                       A [BR_SIZE-1:0],
    output logic [NBITS-1:0]                       B [BR_SIZE-1:0],
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   frame_err
);

    localparam int HALF = BR_SIZE / 2;

    state_t r_state;
    state_t w_next_state;
    beat_t  r_cnt;
    logic   r_frame_err;

    logic       w_accept;
    logic       w_bad_frame;
    logic [3:0] w_we;

    logic [NBITS-1:0] w_a_lo [HALF-1:0];
    logic [NBITS-1:0] w_a_hi [HALF-1:0];
    logic [NBITS-1:0] w_b_lo [HALF-1:0];
    logic [NBITS-1:0] w_b_hi [HALF-1:0];

    assign w_accept    = in_valid && (r_state == COLLECT);
    assign w_bad_frame = w_accept && (in_last != (r_cnt == B_HI));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_we[k] = w_accept && (r_cnt == beat_t'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: if (w_accept && (r_cnt == B_HI) && in_last) w_next_state = HOLD;
            HOLD:    if (out_ready)                               w_next_state = COLLECT;
            default: w_next_state = COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == COLLECT);
        out_valid = (r_state == HOLD);
    end

    // A good beat 3 wraps the counter to A_LO, so HOLD always exits with count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= A_LO;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad_frame;
            if (w_accept) begin
                if (w_bad_frame || (r_cnt == B_HI)) begin
                    r_cnt <= A_LO;
                end else begin
                    r_cnt <= beat_t'(r_cnt + 2'd1);
                end
            end
        end
    end

    assign frame_err = r_frame_err;

    half_unpacker #(.NBITS(NBITS), .HALF(HALF)) u_a_lo (
        .clk(clk), .rst_n(rst_n), .i_we(w_we[A_LO]), .i_word(in_data), .o_elem(w_a_lo)
    );
    half_unpacker #(.NBITS(NBITS), .HALF(HALF)) u_a_hi (
        .clk(clk), .rst_n(rst_n), .i_we(w_we[A_HI]), .i_word(in_data), .o_elem(w_a_hi)
    );
    half_unpacker #(.NBITS(NBITS), .HALF(HALF)) u_b_lo (
        .clk(clk), .rst_n(rst_n), .i_we(w_we[B_LO]), .i_word(in_data), .o_elem(w_b_lo)
    );
    half_unpacker #(.NBITS(NBITS), .HALF(HALF)) u_b_hi (
        .clk(clk), .rst_n(rst_n), .i_we(w_we[B_HI]), .i_word(in_data), .o_elem(w_b_hi)
    );

    always_comb begin
        for (int i = 0; i < HALF; i++) begin
            A[i]        = w_a_lo[i];
            A[i + HALF] = w_a_hi[i];
            B[i]        = w_b_lo[i];
            B[i + HALF] = w_b_hi[i];
        end
    end

endmodule

// File: tb/tb_vectors_unpacker.sv
// Self-checking bench for vectors_unpacker: directed frames from the test
// plan plus a random beat stream, checked against a beat-level frame model.
module tb_vectors_unpacker;

    localparam int NB = 8;
    localparam int BR = 8;
    localparam int HW = NB * BR / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          frame_err;
    logic [NB-1:0] A [BR-1:0];
    logic [NB-1:0] B [BR-1:0];

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: the 16 received elements (A then B), which beat of
    // the frame comes next, whether a frame is being held, and a pending error.
    logic [7:0] mVec [16];
    int         mIdx;
    bit         mHold;
    bit         mErr;

    vectors_unpacker #(.NBITS(NB), .BR_SIZE(BR)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [63:0] packA();
        logic [63:0] r;
        for (int i = 0; i < BR; i++) r[i*8 +: 8] = A[i];
        return r;
    endfunction

    function automatic logic [63:0] packB();
        logic [63:0] r;
        for (int i = 0; i < BR; i++) r[i*8 +: 8] = B[i];
        return r;
    endfunction

    function automatic logic [63:0] modelVec(input int base);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = mVec[base + i];
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mVec[i] = 8'h00;
        mIdx  = 0;
        mHold = 1'b0;
        mErr  = 1'b0;
    endtask

    // Frame rules applied to whatever was on the inputs at this clock edge.
    task automatic modelEdge();
        mErr = 1'b0;
        if (mHold) begin
            if (out_ready) mHold = 1'b0;
        end else if (in_valid) begin
            for (int i = 0; i < 4; i++) mVec[mIdx*4 + i] = in_data[i*8 +: 8];
            if (in_last != (mIdx == 3)) begin
                mErr = 1'b1;
                mIdx = 0;
            end else if (mIdx == 3) begin
                mHold = 1'b1;
                mIdx  = 0;
            end else begin
                mIdx++;
            end
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, " in_ready"},  64'(in_ready),  64'(!mHold));
        checkOutput({where, " out_valid"}, 64'(out_valid), 64'(mHold));
        checkOutput({where, " frame_err"}, 64'(frame_err), 64'(mErr));
        checkOutput({where, " A"}, packA(), modelVec(0));
        checkOutput({where, " B"}, packB(), modelVec(8));
    endtask

    // One clock: drive inputs, let the edge happen, then compare 1 ns later.
    task automatic applyStimulus(input logic v, input logic l, input logic [HW-1:0] d,
                                 input logic r, input string where, output bit accepted);
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = r;
        accepted  = v && in_ready;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(where);
    endtask

    task automatic sendBeat(input logic [HW-1:0] d, input logic l, input logic r, input string where);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            applyStimulus(1'b1, l, d, r, where, acc);
            tries++;
        end
        if (!acc) checkOutput({where, " beat accept timeout"}, 64'(tries), 64'(0));
    endtask

    task automatic idle(input int n, input logic r, input string where);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, r, where, acc);
    endtask

    task automatic sendFrame(input logic [7:0] base, input logic r, input string where);
        for (int k = 0; k < 4; k++) begin
            logic [HW-1:0] w;
            for (int i = 0; i < 4; i++) w[i*8 +: 8] = base + 8'(k*4 + i);
            sendBeat(w, (k == 3), r, where);
        end
    endtask

    task automatic doReset(input string where);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b0;
        #1;
        modelReset();
        checkAll({where, " async"});
        checkOutput({where, " A zero"}, packA(), 64'h0);
        checkOutput({where, " B zero"}, packB(), 64'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll({where, " released"});
    endtask

    initial begin
        bit acc;
        modelReset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("reset");
        checkOutput("reset in_ready const", 64'(in_ready), 64'd1);
        checkOutput("reset A const", packA(), 64'h0);

        // Clean frame held for 10 cycles while the sender keeps offering data.
        sendBeat(32'h03020100, 1'b0, 1'b0, "clean");
        sendBeat(32'h07060504, 1'b0, 1'b0, "clean");
        sendBeat(32'h13121110, 1'b0, 1'b0, "clean");
        sendBeat(32'h17161514, 1'b1, 1'b0, "clean");
        checkOutput("clean out_valid const", 64'(out_valid), 64'd1);
        checkOutput("clean A const", packA(), 64'h0706050403020100);
        checkOutput("clean B const", packB(), 64'h1716151413121110);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, "hold", acc);
        checkOutput("hold A frozen", packA(), 64'h0706050403020100);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, "release", acc);
        checkOutput("release in_ready const", 64'(in_ready), 64'd1);

        // Back-to-back frames with the consumer always ready.
        for (int f = 0; f < 3; f++) sendFrame(8'(8'h20 + f*8'h20), 1'b1, "b2b");
        idle(2, 1'b1, "b2b tail");

        // Early in_last on beat 1, then a good frame.
        sendBeat(32'hA3A2A1A0, 1'b0, 1'b0, "early");
        sendBeat(32'hA7A6A5A4, 1'b1, 1'b0, "early");
        checkOutput("early frame_err const", 64'(frame_err), 64'd1);
        idle(1, 1'b0, "early gap");
        sendFrame(8'h40, 1'b0, "after early");
        checkOutput("after early A const", packA(), 64'h4746454443424140);
        idle(1, 1'b1, "after early rel");

        // Missing in_last on beat 3, then a good frame.
        sendFrame(8'h60, 1'b0, "pre-miss");
        idle(1, 1'b1, "pre-miss rel");
        for (int k = 0; k < 4; k++) sendBeat(32'h55555555, 1'b0, 1'b0, "miss");
        checkOutput("miss frame_err const", 64'(frame_err), 64'd1);
        sendFrame(8'h80, 1'b0, "after miss");
        checkOutput("after miss B const", packB(), 64'h8F8E8D8C8B8A8988);
        idle(1, 1'b1, "after miss rel");

        // Reset after beat 2, and again while holding a frame.
        sendBeat(32'h11111111, 1'b0, 1'b0, "mid");
        sendBeat(32'h22222222, 1'b0, 1'b0, "mid");
        sendBeat(32'h33333333, 1'b0, 1'b0, "mid");
        doReset("rst mid");
        sendFrame(8'hC0, 1'b0, "post rst");
        doReset("rst hold");
        sendFrame(8'hE0, 1'b1, "post rst2");
        idle(1, 1'b0, "post rst2 idle");

        // Random stream with occasional framing errors and consumer stalls.
        for (int c = 0; c < 400; c++) begin
            logic v, l, r;
            v = ($urandom_range(0, 3) != 0);
            l = (mIdx == 3) ^ ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 2) != 0);
            applyStimulus(v, l, HW'($urandom), r, "rand", acc);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
